// File: rtl/sampled_pair_checker.sv
// -----------------------------------------------------------------------------
// sampled_pair_checker
//
// Purpose:
//   Cycle-accurate RTL equivalent of a sampled-equality property. Each clock in
//   RUN it registers copies of streams a and b (a_q/b_q). One cycle later it
//   compares those copies. Over a run of CYCLES samples it counts equal and
//   unequal compares and captures the first mismatch (index, a_q, b_q).
//
//   Timeline for a start accepted at edge E0:
//     E1 .. E_CYCLES      samples captured (index 0 .. CYCLES-1)
//     E2 .. E_(CYCLES+1)  compare results registered
//     after E_(CYCLES+1)  done = 1, held until the next accepted start
//
// Optional build macro:
//   SAMPLED_PAIR_CHECKER_STOP_ON_FAIL_EN
//     When defined, the compare edge that records the first mismatch moves the
//     FSM straight to DONE (from RUN or DRAIN). No further samples are captured.
//     When undefined, none of this logic exists and every run takes all CYCLES
//     samples.
//
// Parameters:
//   WIDTH   width of a and b
//   CYCLES  samples per run (>= 1)
//   CNT_W   width of the counters and sample index (derived, do not override)
//
// Ports:
//   clk             clock; all state changes on the rising edge
//   rst_n           asynchronous active-low reset
//   start           begin a run; accepted only in IDLE or DONE
//   a, b            streams sampled on the rising edge
//   busy            high in RUN and DRAIN
//   done            high in DONE; held until the next accepted start
//   pass            done and no mismatches (combinational)
//   pass_cnt        number of equal compares in this run
//   fail_cnt        number of unequal compares in this run
//   first_fail_idx  0-based sample index of the first mismatch
//   first_fail_a    a_q at the first mismatch
//   first_fail_b    b_q at the first mismatch
//   first_fail_vld  a mismatch has been captured in this run
// -----------------------------------------------------------------------------
module sampled_pair_checker #(
  parameter int WIDTH  = 4,
  parameter int CYCLES = 10,
  parameter int CNT_W  = $clog2(CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [WIDTH-1:0] first_fail_a,
  output logic [WIDTH-1:0] first_fail_b,
  output logic             first_fail_vld
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state;
  logic [CNT_W-1:0] sample_idx;  // index of the next sample to capture
  logic [CNT_W-1:0] cmp_idx;     // index of the pair currently held in a_q/b_q
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             v_q;         // a_q/b_q hold a pair awaiting compare

  logic last_capture;
  logic cmp_eq;
  logic first_miss;

  assign last_capture = (sample_idx == LAST_IDX);
  assign cmp_eq       = (a_q == b_q);
  // True on the compare edge that records the first mismatch of the run.
  assign first_miss   = v_q && !cmp_eq && !first_fail_vld;

  assign pass = done && (fail_cnt == '0);

  // NOTE: every register below uses non-blocking assignment so that the
  // compare stage sees the a_q/b_q/cmp_idx values from before this edge,
  // which is what gives the one-cycle capture-to-compare pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      sample_idx     <= '0;
      cmp_idx        <= '0;
      a_q            <= '0;
      b_q            <= '0;
      v_q            <= 1'b0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_fail_idx <= '0;
      first_fail_a   <= '0;
      first_fail_b   <= '0;
      first_fail_vld <= 1'b0;
    end else begin
      // Compare stage: grades the pair captured on the previous edge.
      // Counters saturate rather than wrap.
      if (v_q) begin
        if (cmp_eq) begin
          if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + 1'b1;
        end else begin
          if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + 1'b1;
        end
        if (first_miss) begin
          first_fail_idx <= cmp_idx;
          first_fail_a   <= a_q;
          first_fail_b   <= b_q;
          first_fail_vld <= 1'b1;
        end
      end

      // Control FSM. Assignments here come after the compare stage so an
      // accepted start always wins the clear (v_q is already 0 in IDLE/DONE).
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= RUN;
            busy           <= 1'b1;
            done           <= 1'b0;
            sample_idx     <= '0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_idx <= '0;
            first_fail_a   <= '0;
            first_fail_b   <= '0;
            first_fail_vld <= 1'b0;
          end
        end

        RUN: begin
`ifdef SAMPLED_PAIR_CHECKER_STOP_ON_FAIL_EN
          if (first_miss) begin
            // Halt on the first mismatch: no capture on this edge.
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            v_q   <= 1'b0;
          end else
`endif
          begin
            a_q        <= a;
            b_q        <= b;
            v_q        <= 1'b1;
            cmp_idx    <= sample_idx;
            sample_idx <= sample_idx + 1'b1;
            // The final sample is captured here; its compare lands in DRAIN.
            if (last_capture) state <= DRAIN;
          end
        end

        DRAIN: begin
          v_q   <= 1'b0;
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sampled_pair_checker.sv
// -----------------------------------------------------------------------------
// tb_sampled_pair_checker
//
// Scoreboard bench for sampled_pair_checker. The stimulus process drives one
// run at a time, computes the expected run result from the raw sample lists
// and pushes it into a queue. A separate monitor pops an entry whenever done
// rises and compares counts, first-mismatch capture and the edge on which
// done appeared. Honours SAMPLED_PAIR_CHECKER_STOP_ON_FAIL_EN in the model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sampled_pair_checker;

  localparam int WIDTH  = 4;
  localparam int CYCLES = 10;
  localparam int CNT_W  = $clog2(CYCLES + 1);

  typedef logic [WIDTH-1:0] vec_t [CYCLES];

  typedef struct {
    int done_edge;
    int pcnt;
    int fcnt;
    int pass;
    int vld;
    int fidx;
    int fa;
    int fb;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic [CNT_W-1:0] first_fail_idx;
  logic [WIDTH-1:0] first_fail_a;
  logic [WIDTH-1:0] first_fail_b;
  logic             first_fail_vld;

  int   total = 0;
  int   bad = 0;
  int   edge_cnt = 0;
  exp_t exp_q[$];

  sampled_pair_checker #(
    .WIDTH (WIDTH),
    .CYCLES(CYCLES)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .a             (a),
    .b             (b),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .pass_cnt      (pass_cnt),
    .fail_cnt      (fail_cnt),
    .first_fail_idx(first_fail_idx),
    .first_fail_a  (first_fail_a),
    .first_fail_b  (first_fail_b),
    .first_fail_vld(first_fail_vld)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt++;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: grade the sample lists pair by pair.
  function automatic exp_t model(input vec_t av, input vec_t bv, input int e0);
    exp_t r;
    int   n;
    r = '{default: 0};
    n = CYCLES;
    for (int i = 0; i < CYCLES; i++) begin
      if (av[i] == bv[i]) begin
        r.pcnt++;
      end else begin
        r.fcnt++;
        if (r.vld == 0) begin
          r.vld  = 1;
          r.fidx = i;
          r.fa   = int'(av[i]);
          r.fb   = int'(bv[i]);
        end
`ifdef SAMPLED_PAIR_CHECKER_STOP_ON_FAIL_EN
        n = i + 1;
        break;
`endif
      end
    end
    // Sample i is compared on edge e0 + i + 2; done follows the last compare.
    r.done_edge = e0 + n + 1;
    r.pass      = (r.fcnt == 0) ? 1 : 0;
    return r;
  endfunction

  // Monitor: grade each completed run when done rises.
  bit   done_prev = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      done_prev = 1'b0;
    end else begin
      if (done && !done_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("done_edge", edge_cnt, mon_e.done_edge);
          check("pass_cnt", int'(pass_cnt), mon_e.pcnt);
          check("fail_cnt", int'(fail_cnt), mon_e.fcnt);
          check("pass", int'(pass), mon_e.pass);
          check("first_fail_vld", int'(first_fail_vld), mon_e.vld);
          check("first_fail_idx", int'(first_fail_idx), mon_e.fidx);
          check("first_fail_a", int'(first_fail_a), mon_e.fa);
          check("first_fail_b", int'(first_fail_b), mon_e.fb);
          check("busy_at_done", int'(busy), 0);
        end
      end
      done_prev = done;
    end
  end

  function automatic int all_outputs();
    return int'({busy, done, pass, pass_cnt, fail_cnt, first_fail_idx,
                 first_fail_a, first_fail_b, first_fail_vld});
  endfunction

  // One complete run; pulse_at >= 0 raises start while that sample is driven.
  task automatic run_stream(input vec_t av, input vec_t bv, input int pulse_at);
    int e0;
    int waited;
    @(negedge clk);
    start = 1'b1;
    a     = WIDTH'($urandom);
    b     = WIDTH'($urandom);
    @(posedge clk);
    #1;
    e0 = edge_cnt;
    exp_q.push_back(model(av, bv, e0));
    for (int k = 0; k < CYCLES; k++) begin
      @(negedge clk);
      start = (k == pulse_at);
      a     = av[k];
      b     = bv[k];
    end
    @(negedge clk);
    start = 1'b0;
    a     = WIDTH'($urandom);
    b     = WIDTH'($urandom);
    waited = 0;
    while (!done && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("done_reached", int'(done), 1);
  endtask

  vec_t va;
  vec_t vb;
  int   base;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outputs(), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_outputs", all_outputs(), 0);

    // 1: matched streams
    for (int i = 0; i < CYCLES; i++) begin va[i] = WIDTH'(i); vb[i] = WIDTH'(i); end
    run_stream(va, vb, -1);

    // 2: offset streams
    for (int i = 0; i < CYCLES; i++) begin va[i] = WIDTH'(i); vb[i] = WIDTH'(i + 1); end
    run_stream(va, vb, -1);

    // 3: single glitch at index 3
    for (int i = 0; i < CYCLES; i++) begin va[i] = WIDTH'(i); vb[i] = WIDTH'(i); end
    vb[3] = WIDTH'(7);
    run_stream(va, vb, -1);

    // 5: restart from DONE with matched streams
    for (int i = 0; i < CYCLES; i++) begin va[i] = WIDTH'(i); vb[i] = WIDTH'(i); end
    run_stream(va, vb, -1);

    // 4b: start pulsed mid-run is ignored
    run_stream(va, vb, 4);

    // Wrapping data values are ordinary data
    for (int i = 0; i < CYCLES; i++) begin va[i] = WIDTH'(12 + i); vb[i] = WIDTH'(12 + i); end
    run_stream(va, vb, -1);

    // 4a: reset between E5 and E6 of a matched run
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      start = 1'b0;
      a     = WIDTH'(k);
      b     = WIDTH'(k);
    end
    @(negedge clk);
    check("busy_mid_run", int'(busy), 1);
    check("pass_cnt_mid_run", int'(pass_cnt), 4);
    rst_n = 1'b0;
    #1;
    check("abort_outputs", all_outputs(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_abort_idle", all_outputs(), 0);

    // Randomized runs
    for (int r = 0; r < 10; r++) begin
      base = int'($urandom_range(0, 3));
      for (int i = 0; i < CYCLES; i++) begin
        va[i] = WIDTH'($urandom);
        vb[i] = ($urandom_range(0, 3) < base) ? WIDTH'($urandom) : va[i];
      end
      run_stream(va, vb, -1);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/sampled_pair_checker.md
Name: sampled_pair_checker

Overview:
- Downstream consumer of two clocked stimulus streams; performs the sampled-equality check in RTL rather than as an SVA property.
- Each clock it registers a sampled copy of inputs `a` and `b`, then compares the copies one cycle later.
- Over a fixed-length run window it accumulates pass/fail counts and captures the first mismatch.
- Used in regression benches to cross-check assertion-engine results cycle for cycle.

Parameters:
- WIDTH, 4: width of `a` and `b`.
- CYCLES, 10: number of samples per run; legal range >= 1.
- CNT_W, $clog2(CYCLES+1): width of counters and sample index (derived; do not override).

Ports:
- clk  in  1: single clock; all state updates on posedge.
- rst_n  in  1: asynchronous, active-low reset.
- start  in  1: begin a run; honoured only in IDLE or DONE.
- a  in  WIDTH: stream A, sampled at posedge.
- b  in  WIDTH: stream B, sampled at posedge.
- busy  out  1: high in RUN and DRAIN.
- done  out  1: high in DONE; held until the next start.
- pass  out  1: done && (fail_cnt == 0).
- pass_cnt  out  CNT_W: number of equal compares.
- fail_cnt  out  CNT_W: number of unequal compares.
- first_fail_idx  out  CNT_W: sample index (0-based) of the first mismatch.
- first_fail_a  out  WIDTH: a_q value at the first mismatch.
- first_fail_b  out  WIDTH: b_q value at the first mismatch.
- first_fail_vld  out  1: a mismatch has been captured in the current run.

Behaviour:
- Reset (async assert, any state):
  - State -> IDLE.
  - All outputs, counters, sample registers and the valid flag -> 0.
  - Deassertion is synchronous to clk by convention.
- FSM states: IDLE, RUN, DRAIN, DONE.
- Transitions:
  - IDLE or DONE, start=1: clear counters, sample index and first_fail_*; next state RUN.
  - RUN, other than on the edge where the sample index reaches CYCLES:
    - Capture a_q <= a, b_q <= b, set v_q <= 1.
    - Increment the sample index.
  - RUN, on that final capture edge (index reaches CYCLES): next state DRAIN.
  - DRAIN: v_q <= 0; the final compare lands; next state DONE.
  - DONE: start=1 restarts the run; otherwise hold state.
- Compare stage:
  - Active on every edge where v_q=1.
  - a_q == b_q: pass_cnt += 1.
  - Otherwise: fail_cnt += 1. If first_fail_vld=0, also load first_fail_idx/a/b and set first_fail_vld.
  - Compare index = capture index of that pair, tracked via a delayed copy of the index.
- Latency:
  - Start is taken at edge E0; samples are captured at E1..E_CYCLES.
  - Compare results are registered at E2..E_(CYCLES+1).
  - done=1 after E_(CYCLES+1).
  - Worked example, CYCLES=10: done rises after the 11th edge following the start edge.
- start while busy: ignored, with no effect on counters.
- Counters: pass_cnt + fail_cnt == CYCLES at DONE. Counters saturate at all-ones; unreachable with the derived CNT_W but required.
- Comparison: full WIDTH-bit equality; no X handling (2-state semantics).
- Wrap-around: input values wrapping from 2^WIDTH-1 to 0 are ordinary data.
- pass: combinational from state and fail_cnt; 0 outside DONE.
- Reset mid-run: aborts immediately; no partial result is retained.

Optional Feature:
- Macro: SAMPLED_PAIR_CHECKER_STOP_ON_FAIL_EN.
- Defined:
  - On the compare edge that records the first mismatch, the FSM goes directly to DONE, even from RUN.
  - Further captures are suppressed.
  - pass_cnt + fail_cnt = number of compares performed, with fail_cnt = 1.
- Undefined: the run always completes all CYCLES samples.
- Feature logic must be fully absent from RTL when the macro is undefined.

Test Plan:
1. Matched streams: a=b=0..9 over E1..E10, CYCLES=10.
   - Expect done after E11, pass_cnt=10, fail_cnt=0, pass=1, first_fail_vld=0.
2. Offset streams: a=0..9, b=1..10.
   - Expect fail_cnt=10, pass_cnt=0, first_fail_idx=0, first_fail_a=0, first_fail_b=1, pass=0.
3. Single glitch: a=b=0..9 except b=7 at index 3.
   - Expect fail_cnt=1, pass_cnt=9, first_fail_idx=3, first_fail_a=3, first_fail_b=7.
4. Reset mid-run and start handling:
   - Assert rst_n=0 between E5 and E6: immediately state IDLE, all outputs 0, busy=0.
   - Pulse start during RUN of a fresh run: no effect; counts still total 10.
5. Restart from DONE after scenario 3, then feed matched streams.
   - Expect counters cleared, first_fail_vld=0, final pass=1.
6. With SAMPLED_PAIR_CHECKER_STOP_ON_FAIL_EN, using scenario 3 stimulus.
   - Expect done after E5, pass_cnt=3, fail_cnt=1, first_fail_idx=3.
   - Without the macro: same results as scenario 3.
